// File: rtl/camo_pkg.sv
// Shared types and the cell evaluation function for the camouflaged gate bank.
package camo_pkg;

    // Width of the key slice that selects one cell's logic function.
    localparam int CAMO_CODE_W = 2;

    typedef enum logic [CAMO_CODE_W-1:0] {
        CAMO_NAND = 2'b00,
        CAMO_XOR  = 2'b01,
        CAMO_NOR  = 2'b10,
        CAMO_XNOR = 2'b11
    } camo_code_e;

    typedef enum logic [1:0] {
        UNKEYED = 2'b00,
        LOADING = 2'b01,
        LOCKED  = 2'b10
    } camo_state_e;

    // Evaluates one camouflaged cell. Code 11 is XNOR, unlike the older
    // single gate, which repeated XOR on that code.
    function automatic logic camo_eval(camo_code_e code, logic a, logic b);
        logic y;
        case (code)
            CAMO_NAND: y = ~(a & b);
            CAMO_XOR:  y = a ^ b;
            CAMO_NOR:  y = ~(a | b);
            CAMO_XNOR: y = ~(a ^ b);
            default:   y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/camo_cell.sv
// One camouflaged 2-input cell: the 2-bit key slice picks its logic function.
module camo_cell
    import camo_pkg::*;
(
    input  logic [CAMO_CODE_W-1:0] key,
    input  logic                   a,
    input  logic                   b,
    output logic                   y
);

    assign y = camo_eval(camo_code_e'(key), a, b);

endmodule

// File: rtl/camo_gate_bank.sv
// Key-programmable bank of camouflaged cells. The key arrives serially into a
// shadow register and only reaches the cells once every beat has landed, so
// a partial key can never be observed through the datapath.
module camo_gate_bank
    import camo_pkg::*;
#(
    parameter int NUM_CELLS = 8,
    parameter int BEAT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_start,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [BEAT_W-1:0]    key_data,
    output logic                 locked,
    input  logic                 in_valid,
    input  logic [NUM_CELLS-1:0] in_a,
    input  logic [NUM_CELLS-1:0] in_b,
    output logic                 out_valid,
    output logic [NUM_CELLS-1:0] out_y
);

    localparam int KEY_W = CAMO_CODE_W * NUM_CELLS;
    localparam int BEATS = KEY_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    camo_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [KEY_W-1:0]     shadow_q, shadow_d;
    logic [KEY_W-1:0]     active_q, active_d;
    logic [NUM_CELLS-1:0] outY_q;
    logic                 outValid_q;
    logic [NUM_CELLS-1:0] cellY;

    // Key-load FSM: a restart always wins over a beat, including the final one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        key_ready = 1'b0;
        locked    = 1'b0;
        case (state_q)
            UNKEYED: begin
                if (key_start) begin
                    state_d  = LOADING;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            LOADING: begin
                key_ready = 1'b1;
                if (key_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (key_valid) begin
                    shadow_d[cnt_q*BEAT_W +: BEAT_W] = key_data;
                    if (cnt_q == LAST_BEAT) begin
                        active_d = shadow_d;
                        cnt_d    = '0;
                        state_d  = LOCKED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                locked = 1'b1;
                if (key_start) begin
                    state_d  = LOADING;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            default: begin
                state_d = UNKEYED;
            end
        endcase
    end

    // Control and key registers; reset discards both shadow and active keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= UNKEYED;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            camo_cell u_cell (
                .key (active_q[gi*CAMO_CODE_W +: CAMO_CODE_W]),
                .a   (in_a[gi]),
                .b   (in_b[gi]),
                .y   (cellY[gi])
            );
        end
    endgenerate

    // Result register: captures only while locked, otherwise holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outY_q     <= '0;
            outValid_q <= 1'b0;
        end else if (in_valid && (state_q == LOCKED)) begin
            outY_q     <= cellY;
            outValid_q <= 1'b1;
        end else begin
            outValid_q <= 1'b0;
        end
    end

    assign out_y     = outY_q;
    assign out_valid = outValid_q;

endmodule
